controle_t: RTL and testbench
=============================

CONTROLE_T -- requirements
Module: controle_t

Interface
- REQ-001 The block SHALL have ports: clk  in  1  rising-edge clock.
- REQ-002 rst  in  1  synchronous, active-high reset.
- REQ-003 instr_valid  in  1  opcode presented this cycle.
- REQ-004 opcode  in  3  instruction code, sampled on acceptance.
- REQ-005 instr_ready  out  1  block idle, can accept.
- REQ-006 Tx, Ty, Tz  out  2 each  register commands: 00 RESET, 01 LOAD, 10 HOLD; 11 never driven.
- REQ-007 alu_sel  out  2  ALU operation: 00 PASS, 01 ADD, 10 SUB.
- REQ-008 done  out  1  one-cycle pulse in the final phase of an instruction.
- REQ-009 err  out  1  one-cycle illegal-opcode pulse (see Configuration).

Function
- REQ-010 The FSM SHALL have the states IDLE, P1 and P2; all outputs SHALL be decoded from the state register and the latched opcode only (Moore).
- REQ-011 instr_ready SHALL be 1 only in IDLE; acceptance occurs on a rising edge where instr_valid=1 and instr_ready=1, latching opcode and moving to P1.
- REQ-012 Commands not listed for a phase SHALL be HOLD (10) and alu_sel SHALL be PASS.
- REQ-013 Opcode 000 NOP: P1 all HOLD, done=1, then IDLE.
- REQ-014 Opcode 001 CLR: P1 Tx=Ty=Tz=RESET, done=1, then IDLE.
- REQ-015 Opcode 010 LDY: P1 Ty=LOAD, done=1, then IDLE.
- REQ-016 Opcode 011 LDZ: P1 Tz=LOAD, done=1, then IDLE.
- REQ-017 Opcode 100 ADD: P1 alu_sel=ADD and Tx=LOAD, done=0; P2 Ty=RESET and done=1, then IDLE.
- REQ-018 Opcode 101 SUB: same as ADD with alu_sel=SUB in P1.
- REQ-019 Opcodes 110/111 (illegal): P1 all HOLD and done=1, then IDLE; no register is modified.
- REQ-020 Latency: one-phase ops SHALL occupy 1 cycle after acceptance and two-phase ops 2; the minimum accept-to-accept interval SHALL be 2 cycles or 3 cycles, respectively.
- REQ-021 instr_valid and opcode SHALL be ignored outside IDLE; opcode changes after acceptance SHALL NOT affect the executing instruction.
- REQ-022 done SHALL never be high on two consecutive cycles.

Reset
- REQ-023 While rst=1 the outputs SHALL be Tx=Ty=Tz=RESET, alu_sel=PASS, done=0, err=0 and instr_ready=0, and the state SHALL be forced to IDLE.
- REQ-024 On the first cycle after rst falls the outputs SHALL be in IDLE: all commands HOLD and instr_ready=1.
- REQ-025 rst asserted in P1 or P2 SHALL abort the instruction with no done pulse; rst SHALL take priority over acceptance.

Configuration
- REQ-026 With macro CONTROLE_T_ERR_EN defined, err SHALL pulse together with done for opcodes 110 and 111.
- REQ-027 Without CONTROLE_T_ERR_EN, err SHALL be a constant 0, with no other behavioural change.

Structure
- REQ-028 A shared package controle_pkg SHALL hold the T-code constants (T_RESET, T_LOAD, T_HOLD), the alu_sel constants, the opcode constants and the state encoding; register blocks SHALL use the same T constants.
- REQ-029 A combinational sub-module controle_decode SHALL map (state, latched opcode) to {Tx, Ty, Tz, alu_sel, done, last_phase}; controle_t SHALL hold only the state and opcode registers and the handshake logic.

Verification
- REQ-030 Hold rst for 3 cycles and then release -> during reset T=00/00/00 and ready=0; the next cycle shows T=10/10/10 and ready=1.
- REQ-031 Accept LDY (010) -> the next cycle shows Ty=01, Tx=Tz=10 and done=1; the cycle after that shows ready=1.
- REQ-032 Accept ADD (100), then change opcode to 001 while busy -> P1 shows alu_sel=01 and Tx=01; P2 shows Ty=00 and done=1; there is no CLR effect.
- REQ-033 Accept SUB (101) and assert rst in P1 -> no done pulse, T=00/00/00 during reset, and IDLE after release.
- REQ-034 Accept 111 with and without CONTROLE_T_ERR_EN -> all HOLD and done=1; err=1 only when the macro is defined.
- REQ-035 Hold instr_valid=1 continuously with LDZ -> Tz=01 pulses every 2 cycles and is never HOLD-violated in between.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared constants for the controle_t instruction controller: register
// command codes (also used by the register blocks), ALU selects, opcodes
// and the FSM state encoding.
package controle_pkg;

  // Register commands
  localparam logic [1:0] T_RESET = 2'b00;
  localparam logic [1:0] T_LOAD  = 2'b01;
  localparam logic [1:0] T_HOLD  = 2'b10;

  // ALU operation selects
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // Opcodes (110 and 111 are illegal)
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_LDY  = 3'b010;
  localparam logic [2:0] OP_LDZ  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_IL6  = 3'b110;
  localparam logic [2:0] OP_IL7  = 3'b111;

  // FSM state encoding
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_P1   = 2'b01;
  localparam logic [1:0] S_P2   = 2'b10;

  // Illegal opcodes are the two codes with both upper bits set.
  function automatic logic is_illegal(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/controle_t_if.sv
// Instruction handshake and control-output bundle of controle_t.
// Ports: instr_valid/opcode (to controller), instr_ready, Tx/Ty/Tz,
// alu_sel, done, err (from controller).
interface controle_t_if;
  logic       instr_valid;
  logic [2:0] opcode;
  logic       instr_ready;
  logic [1:0] Tx;
  logic [1:0] Ty;
  logic [1:0] Tz;
  logic [1:0] alu_sel;
  logic       done;
  logic       err;

  // Instruction source side
  modport master (
    output instr_valid, opcode,
    input  instr_ready, Tx, Ty, Tz, alu_sel, done, err
  );

  // Controller side
  modport slave (
    input  instr_valid, opcode,
    output instr_ready, Tx, Ty, Tz, alu_sel, done, err
  );
endinterface

// File: rtl/controle_decode.sv
// Combinational phase decoder: (state, latched opcode) -> register commands,
// ALU select, done and last_phase. Ports: state_i, opcode_i in; tx_o, ty_o,
// tz_o, alu_sel_o, done_o, last_phase_o out. Zero latency, no handshake.
module controle_decode
  import controle_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic [2:0] opcode_i,
  output logic [1:0] tx_o,
  output logic [1:0] ty_o,
  output logic [1:0] tz_o,
  output logic [1:0] alu_sel_o,
  output logic       done_o,
  output logic       last_phase_o
);

  always_comb begin
    tx_o         = T_HOLD;
    ty_o         = T_HOLD;
    tz_o         = T_HOLD;
    alu_sel_o    = ALU_PASS;
    done_o       = 1'b0;
    last_phase_o = 1'b0;
    case (state_i)
      S_P1: begin
        case (opcode_i)
          OP_NOP: begin
            done_o       = 1'b1;
            last_phase_o = 1'b1;
          end
          OP_CLR: begin
            tx_o         = T_RESET;
            ty_o         = T_RESET;
            tz_o         = T_RESET;
            done_o       = 1'b1;
            last_phase_o = 1'b1;
          end
          OP_LDY: begin
            ty_o         = T_LOAD;
            done_o       = 1'b1;
            last_phase_o = 1'b1;
          end
          OP_LDZ: begin
            tz_o         = T_LOAD;
            done_o       = 1'b1;
            last_phase_o = 1'b1;
          end
          OP_ADD: begin
            alu_sel_o = ALU_ADD;
            tx_o      = T_LOAD;
          end
          OP_SUB: begin
            alu_sel_o = ALU_SUB;
            tx_o      = T_LOAD;
          end
          default: begin
            // Illegal opcodes: everything holds, instruction still completes.
            done_o       = 1'b1;
            last_phase_o = 1'b1;
          end
        endcase
      end
      S_P2: begin
        // Second phase only exists for ADD/SUB: clear Y after X took the result.
        ty_o         = T_RESET;
        done_o       = 1'b1;
        last_phase_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/controle_t.sv
// Moore instruction controller: accepts an opcode in IDLE and sequences 1 or
// 2 command phases (P1/P2). Ports: clk, rst (sync, active-high), bus (slave).
// Optional: CONTROLE_T_ERR_EN enables the illegal-opcode err pulse.
module controle_t
  import controle_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  controle_t_if.slave  bus
);

  logic [1:0] state_q, state_d;
  logic [2:0] opcode_q, opcode_d;

  logic [1:0] tx_dec, ty_dec, tz_dec, alu_dec;
  logic       done_dec, last_dec;

  controle_decode u_decode (
    .state_i      (state_q),
    .opcode_i     (opcode_q),
    .tx_o         (tx_dec),
    .ty_o         (ty_dec),
    .tz_o         (tz_dec),
    .alu_sel_o    (alu_dec),
    .done_o       (done_dec),
    .last_phase_o (last_dec)
  );

  // Opcode is captured only on acceptance, so later bus changes are ignored.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          state_d  = S_P1;
          opcode_d = bus.opcode;
        end
      end
      S_P1:    state_d = last_dec ? S_IDLE : S_P2;
      default: state_d = S_IDLE;  // P2 and the unused encoding
    endcase
  end

  // Reset wins over acceptance and aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_NOP;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // While rst is high the registers are driven to RESET and nothing completes,
  // even in the cycle rst is first raised during P1/P2.
  assign bus.instr_ready = ~rst & (state_q == S_IDLE);
  assign bus.Tx          = rst ? T_RESET  : tx_dec;
  assign bus.Ty          = rst ? T_RESET  : ty_dec;
  assign bus.Tz          = rst ? T_RESET  : tz_dec;
  assign bus.alu_sel     = rst ? ALU_PASS : alu_dec;
  assign bus.done        = ~rst & done_dec;

`ifdef CONTROLE_T_ERR_EN
  assign bus.err = ~rst & (state_q == S_P1) & is_illegal(opcode_q);
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_controle_t.sv
module tb_controle_t;
  import controle_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controle_t_if bus();
  controle_t dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Output vector: {ready, Tx, Ty, Tz, alu_sel, done, err}
  typedef logic [11:0] vec_t;

`ifdef CONTROLE_T_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a queue of the per-cycle outputs still owed by the instruction in
  // flight; empty queue means idle.
  vec_t exp_q[$];
  logic prev_done = 1'b0;

  function automatic vec_t mk(logic rdy, logic [1:0] x, logic [1:0] y, logic [1:0] z,
                              logic [1:0] a, logic d, logic e);
    return {rdy, x, y, z, a, d, e};
  endfunction

  localparam logic [1:0] R = 2'b00, L = 2'b01, H = 2'b10;

  task automatic push_instr(input logic [2:0] op);
    case (op)
      3'd0: exp_q.push_back(mk(0, H, H, H, 2'b00, 1, 0));
      3'd1: exp_q.push_back(mk(0, R, R, R, 2'b00, 1, 0));
      3'd2: exp_q.push_back(mk(0, H, L, H, 2'b00, 1, 0));
      3'd3: exp_q.push_back(mk(0, H, H, L, 2'b00, 1, 0));
      3'd4: begin
        exp_q.push_back(mk(0, L, H, H, 2'b01, 0, 0));
        exp_q.push_back(mk(0, H, R, H, 2'b00, 1, 0));
      end
      3'd5: begin
        exp_q.push_back(mk(0, L, H, H, 2'b10, 0, 0));
        exp_q.push_back(mk(0, H, R, H, 2'b00, 1, 0));
      end
      default: exp_q.push_back(mk(0, H, H, H, 2'b00, 1, ERR_EN));
    endcase
  endtask

  function automatic vec_t dut_vec();
    return {bus.instr_ready, bus.Tx, bus.Ty, bus.Tz, bus.alu_sel, bus.done, bus.err};
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b required %b at %0t", name, got, want, $time);
    end
  endtask

  // One clock cycle: update the model at the edge with the inputs the DUT
  // sampled, apply new inputs, then compare at the falling edge.
  task automatic step(input logic r, input logic v, input logic [2:0] op);
    vec_t want;
    @(posedge clk);
    if (rst === 1'b1) exp_q.delete();
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
    else if (bus.instr_valid) push_instr(bus.opcode);
    #1;
    rst = r;
    bus.instr_valid = v;
    bus.opcode = op;
    @(negedge clk);
    if (r) want = mk(0, R, R, R, 2'b00, 0, 0);
    else if (exp_q.size() > 0) want = exp_q[0];
    else want = mk(1, H, H, H, 2'b00, 0, 0);
    check("model", dut_vec(), want);
    if (bus.done) check("done_twice", {11'd0, prev_done}, 12'd0);
    prev_done = bus.done;
  endtask

  int tz_loads;

  initial begin
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.opcode = 3'd0;

    // Reset held 3 cycles, then released
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("rst_vec", dut_vec(), 12'b0_00_00_00_00_0_0);
    step(0, 0, 0);
    check("idle_vec", dut_vec(), 12'b1_10_10_10_00_0_0);

    // LDY
    step(0, 1, OP_LDY);
    step(0, 0, 0);
    check("ldy_p1", {6'd0, bus.Tx, bus.Ty, bus.Tz}, {6'd0, 2'b10, 2'b01, 2'b10});
    check("ldy_done", {11'd0, bus.done}, 12'd1);
    step(0, 0, 0);
    check("ldy_ready", {11'd0, bus.instr_ready}, 12'd1);

    // ADD, opcode switched to CLR while busy
    step(0, 1, OP_ADD);
    step(0, 1, OP_CLR);
    check("add_p1", {8'd0, bus.alu_sel, bus.Tx}, {8'd0, 2'b01, 2'b01});
    step(0, 1, OP_CLR);
    check("add_p2", {9'd0, bus.Ty, bus.done}, {9'd0, 2'b00, 1'b1});
    step(0, 0, 0);
    check("add_noclr", {6'd0, bus.Tx, bus.Ty, bus.Tz}, {6'd0, 2'b10, 2'b10, 2'b10});

    // SUB aborted by reset in P1
    step(0, 1, OP_SUB);
    step(0, 0, 0);
    check("sub_p1", {8'd0, bus.alu_sel, bus.Tx}, {8'd0, 2'b10, 2'b01});
    step(1, 0, 0);
    check("sub_abort", dut_vec(), 12'b0_00_00_00_00_0_0);
    step(0, 0, 0);
    check("sub_idle", dut_vec(), 12'b1_10_10_10_00_0_0);

    // Illegal 111
    step(0, 1, OP_IL7);
    step(0, 0, 0);
    check("il7", {bus.Tx, bus.Ty, bus.Tz, bus.alu_sel, bus.done, bus.err},
          {2'b10, 2'b10, 2'b10, 2'b00, 1'b1, ERR_EN});

    // LDZ streamed back-to-back
    tz_loads = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, OP_LDZ);
      if (bus.Tz == 2'b01) tz_loads++;
    end
    check("ldz_rate", 12'(tz_loads), 12'd5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
           3'($urandom_range(0, 7)));
    end
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
